sensor_scan_controller: RTL
===========================

Name: sensor_scan_controller

Overview:
- Scheduler for the shared HC-SR04 interface. One interface instance serves up to 4 ultrasonic sensors, selected by an external trigger/echo mux.
- Triggers measurements round-robin with a fixed inter-measurement interval, and applies a timeout so a dead or missing sensor cannot stall the interface.
- Results leave with a one-cycle valid pulse, tagged with the sensor index.
- Sits between the top-level application FSM (level monitoring) and the interface block.

Parameters:
- N_SENSORES, 4, number of sensors scanned (1..4); sel wraps at N_SENSORES-1.
- INTERVALO, 2_500_000, idle cycles between the end of one measurement and the next medir (50 ms @ 50 MHz).
- TIMEOUT, 1_500_000, maximum cycles waited for pronto after medir (30 ms @ 50 MHz).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- ligar  in  1  level; 1 = scanning enabled
- pronto  in  1  interface done pulse (1 cycle)
- medida  in  12  interface distance result (3 BCD digits), valid while pronto=1
- medir  out  1  1-cycle start pulse to the interface
- reset_if  out  1  1-cycle synchronous clear of the interface after a timeout
- sel  out  2  sensor currently routed through the mux
- dado  out  12  last valid distance
- dado_sensor  out  2  sensor index of the last dado/erro event
- dado_valido  out  1  1-cycle pulse, dado updated
- erro  out  1  1-cycle pulse, timeout on sensor dado_sensor
- db_estado  out  4  state code for 7-seg debug

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- Reset asserted mid-operation returns the block to IDLE immediately. The interface has its own reset and is not pulsed.
- States and db_estado codes: IDLE 0, DISPARA 1, AGUARDA 2, REGISTRA 3, FALHA 4, PROXIMO 5, ESPERA 6. Illegal encodings go to IDLE with db_estado E.
- IDLE: on ligar=1, sel<=0 and go to DISPARA.
- DISPARA: medir=1 for exactly this cycle. Timeout counter cleared. Go to AGUARDA.
- AGUARDA: timeout counter increments each cycle.
  - pronto=1 -> REGISTRA.
  - Otherwise, counter==TIMEOUT-1 -> FALHA.
  - pronto wins if both occur in the same cycle.
  - ligar is ignored here; an in-flight measurement always completes or times out.
- REGISTRA: dado<=medida captured on the pronto cycle (held in a 12-bit capture register), dado_sensor<=sel, dado_valido=1. Go to PROXIMO.
- FALHA: reset_if=1, erro=1, dado_sensor<=sel; dado unchanged. Go to PROXIMO.
- PROXIMO: sel <= (sel==N_SENSORES-1) ? 0 : sel+1.
  - ligar=1 -> ESPERA with the interval counter cleared.
  - ligar=0 -> IDLE.
- ESPERA: the interval counter increments.
  - ligar=0 -> IDLE at the next edge.
  - Counter==INTERVALO-1 -> DISPARA.
- Spacing: from the REGISTRA/FALHA cycle to the next medir cycle is exactly INTERVALO+2 cycles.
- Latency: ligar rises in IDLE -> medir high 1 cycle later (DISPARA).
- pronto outside AGUARDA is ignored. sel is stable from DISPARA through PROXIMO.
- With N_SENSORES=1, sel stays 0.
- Counter width is $clog2(max(INTERVALO,TIMEOUT)+1). Counters saturate, never wrap.

Decomposition:
- Shared package/header (scan_pkg): state encodings, db_estado codes, default INTERVALO/TIMEOUT constants.
- One sub-module: contador_m (parameterised modulo-M counter with synchronous clear, enable and a "fim" output at M-1). Instantiated twice, once for timeout and once for interval.

Test Plan (N_SENSORES=3, INTERVALO=10, TIMEOUT=20):
- Basic scan: ligar=1 from IDLE; pronto with medida=12'h123 after 5 cycles -> medir 1 cycle after ligar; dado=123, dado_sensor=0, dado_valido 1 cycle; next medir exactly 12 cycles after REGISTRA with sel=1.
- Wrap: three successful measurements -> sel sequence 0,1,2,0; dado_sensor tags match.
- Timeout: no pronto on sel=1 -> erro and reset_if high exactly 20 cycles after AGUARDA entry; dado unchanged; next medir uses sel=2.
- Race: pronto on the cycle the counter reaches 19 -> REGISTRA taken, no erro.
- Disable: ligar=0 during AGUARDA -> measurement completes, dado_valido fires, then IDLE with no further medir. ligar=0 during ESPERA -> IDLE next edge.
- Async reset mid-AGUARDA -> all outputs 0 and db_estado=0 without a clock edge; later ligar restarts at sel=0.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared definitions for the sensor scan controller.
//   - scan_state_t : FSM state encoding. The encoding also serves as the
//                    db_estado debug code for legal states.
//   - DB_ILEGAL    : debug code shown for an illegal state encoding.
//   - INTERVALO_PAD / TIMEOUT_PAD : default timing in clock cycles (50 MHz).
//   - cnt_w()      : counter width that can hold max(a,b).
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPARA  = 3'd1,
    AGUARDA  = 3'd2,
    REGISTRA = 3'd3,
    FALHA    = 3'd4,
    PROXIMO  = 3'd5,
    ESPERA   = 3'd6
  } scan_state_t;

  localparam logic [3:0] DB_ILEGAL = 4'hE;

  localparam int INTERVALO_PAD = 2_500_000;  // 50 ms
  localparam int TIMEOUT_PAD   = 1_500_000;  // 30 ms

  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/contador_m.sv
// Modulo-M style counter used for the timeout and interval timers.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   clr          : synchronous clear (has priority over en)
//   en           : count enable
//   fim          : high while the count equals M-1
// The count saturates at M-1 instead of wrapping, so a stalled FSM can
// never see fim disappear and miss its exit condition.
module contador_m #(
  parameter int M = 10,
  parameter int W = $clog2(M + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam logic [W-1:0] MAX = W'(M - 1);

  logic [W-1:0] q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                q <= '0;
    else if (clr)             q <= '0;
    else if (en && q != MAX)  q <= q + W'(1);
  end

  assign fim = (q == MAX);

endmodule

// File: rtl/sensor_scan_controller.sv
// Round-robin scheduler for a shared HC-SR04 interface serving up to four
// ultrasonic sensors through an external trigger/echo mux.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   ligar         : scanning enable (level)
//   pronto/medida : interface done pulse and its 3-digit BCD result
//   medir         : 1-cycle start pulse to the interface
//   reset_if      : 1-cycle synchronous clear of the interface on timeout
//   sel           : sensor routed through the mux
//   dado          : last valid distance
//   dado_sensor   : sensor index of the last dado/erro event
//   dado_valido   : 1-cycle pulse, dado updated
//   erro          : 1-cycle pulse, timeout on sensor dado_sensor
//   db_estado     : state code for 7-segment debug
module sensor_scan_controller
  import scan_pkg::*;
#(
  parameter int N_SENSORES = 4,
  parameter int INTERVALO  = INTERVALO_PAD,
  parameter int TIMEOUT    = TIMEOUT_PAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        pronto,
  input  logic [11:0] medida,
  output logic        medir,
  output logic        reset_if,
  output logic [1:0]  sel,
  output logic [11:0] dado,
  output logic [1:0]  dado_sensor,
  output logic        dado_valido,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int         CW      = cnt_w(INTERVALO, TIMEOUT);
  localparam logic [1:0] SEL_MAX = 2'(N_SENSORES - 1);

  scan_state_t state, next_state;

  logic t_clr, t_en, t_fim;
  logic i_clr, i_en, i_fim;

  contador_m #(.M(TIMEOUT), .W(CW)) u_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (t_clr),
    .en    (t_en),
    .fim   (t_fim)
  );

  contador_m #(.M(INTERVALO), .W(CW)) u_intervalo (
    .clock (clock),
    .reset (reset),
    .clr   (i_clr),
    .en    (i_en),
    .fim   (i_fim)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    medir       = 1'b0;
    reset_if    = 1'b0;
    erro        = 1'b0;
    dado_valido = 1'b0;
    t_clr       = 1'b0;
    t_en        = 1'b0;
    i_clr       = 1'b0;
    i_en        = 1'b0;
    db_estado   = {1'b0, state};
    case (state)
      IDLE:     if (ligar) next_state = DISPARA;
      DISPARA: begin
        medir      = 1'b1;
        t_clr      = 1'b1;
        next_state = AGUARDA;
      end
      // ligar is deliberately not looked at: a measurement in flight always
      // finishes or times out so the interface is never left mid-cycle.
      AGUARDA: begin
        t_en = 1'b1;
        if (pronto)     next_state = REGISTRA;
        else if (t_fim) next_state = FALHA;
      end
      REGISTRA: begin
        dado_valido = 1'b1;
        next_state  = PROXIMO;
      end
      FALHA: begin
        reset_if   = 1'b1;
        erro       = 1'b1;
        next_state = PROXIMO;
      end
      PROXIMO: begin
        if (ligar) begin
          i_clr      = 1'b1;
          next_state = ESPERA;
        end else begin
          next_state = IDLE;
        end
      end
      ESPERA: begin
        i_en = 1'b1;
        if (!ligar)     next_state = IDLE;
        else if (i_fim) next_state = DISPARA;
      end
      default: begin
        db_estado  = DB_ILEGAL;
        next_state = IDLE;
      end
    endcase
  end

  // dado doubles as the capture register: it is loaded on the pronto cycle
  // so the new value is already present while dado_valido is high, and
  // dado_sensor is tagged on the same edge for both outcomes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sel         <= '0;
      dado        <= '0;
      dado_sensor <= '0;
    end else begin
      if (state == IDLE && ligar) sel <= '0;
      if (state == PROXIMO)       sel <= (sel == SEL_MAX) ? 2'd0 : sel + 2'd1;
      if (state == AGUARDA) begin
        if (pronto) begin
          dado        <= medida;
          dado_sensor <= sel;
        end else if (t_fim) begin
          dado_sensor <= sel;
        end
      end
    end
  end

endmodule
